// File: rtl/cgra_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cgra_seq_pkg
// Brief    : Shared state encoding, default widths and helpers for the
//            CGRA tile PC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cgra_seq_pkg;

    localparam int unsigned c_pc_w         = 12;
    localparam int unsigned c_vlen_w       = 10;
    localparam int unsigned c_drain_cycles = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_VECT   = 3'd2,
        S_DRAIN  = 3'd3,
        S_STREAM = 3'd4,
        S_DONE   = 3'd5
    } seq_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cgra_elem_counter.sv
`default_nettype none
// ============================================================================
// Module   : cgra_elem_counter
// Brief    : Loadable element up-counter; o_tc flags the last element of the
//            length captured at load time.
// Revision : 1.0 - initial release
// ============================================================================
module cgra_elem_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_len,
    input  logic         i_adv,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_last;

    // The length is captured once so later changes on the input are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_last <= '0;
        end else if (i_load) begin
            r_cnt  <= '0;
            r_last <= i_len - W'(1);
        end else if (i_adv) begin
            r_cnt  <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == r_last);

endmodule
`default_nettype wire

// File: rtl/cgra_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cgra_pc_sequencer
// Brief    : PC controller for one CGRA tile: scalar, vector and stream-out
//            sequencing. Define CGRA_PC_PERF_CNT_EN to add cycle/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module cgra_pc_sequencer
    import cgra_seq_pkg::*;
#(
    parameter int PC_W         = c_pc_w,
    parameter int VLEN_W       = c_vlen_w,
    parameter int DRAIN_CYCLES = c_drain_cycles
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              instr_valid,
    input  logic              is_not_vect,
    input  logic              is_bne,
    input  logic              flag_neq,
    input  logic              is_vstreamout,
    input  logic              is_halt,
    input  logic [PC_W-1:0]   branch_immediate,
    input  logic [VLEN_W-1:0] vlen,
    input  logic              stream_ready,
    output logic [PC_W-1:0]   pc,
    output logic [VLEN_W-1:0] vect_idx,
    output logic              vect_active,
    output logic              done_auto_incr,
    output logic              done_steady,
    output logic              stream_valid,
    output logic              busy,
    output logic              done
`ifdef CGRA_PC_PERF_CNT_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int c_drain_w = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(DRAIN_CYCLES - 1);

    seq_state_t          r_state, w_state_nxt;
    logic [PC_W-1:0]     r_pc, w_pc_nxt;
    logic                r_vect_active, w_vect_active_nxt;
    logic                r_done_auto_incr, w_done_auto_incr_nxt;
    logic                r_done_steady, w_done_steady_nxt;
    logic                r_stream_valid, w_stream_valid_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic [c_drain_w-1:0] r_drain_cnt, w_drain_cnt_nxt;

    logic                w_cnt_load;
    logic                w_cnt_adv;
    logic                w_cnt_tc;
    logic [VLEN_W-1:0]   w_cnt;
    logic                w_start_clr;
    logic                w_xfer;
    logic [PC_W-1:0]     w_pc_inc;

    assign w_xfer   = r_stream_valid & stream_ready;
    assign w_pc_inc = r_pc + PC_W'(1);

    cgra_elem_counter #(
        .W (VLEN_W)
    ) u_elem_counter (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_cnt_load),
        .i_len  (vlen),
        .i_adv  (w_cnt_adv),
        .o_cnt  (w_cnt),
        .o_tc   (w_cnt_tc)
    );

    always_comb begin
        w_state_nxt          = r_state;
        w_pc_nxt             = r_pc;
        w_vect_active_nxt    = r_vect_active;
        w_done_auto_incr_nxt = 1'b0;
        w_done_steady_nxt    = r_done_steady;
        w_stream_valid_nxt   = r_stream_valid;
        w_done_nxt           = r_done;
        w_drain_cnt_nxt      = r_drain_cnt;
        w_cnt_load           = 1'b0;
        w_cnt_adv            = 1'b0;
        w_start_clr          = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                    w_done_nxt  = 1'b0;
                    w_start_clr = 1'b1;
                end
            end
            S_RUN: begin
                if (instr_valid) begin
                    if (is_halt) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else if (is_vstreamout) begin
                        if (vlen == '0) begin
                            w_pc_nxt = w_pc_inc;
                        end else begin
                            w_state_nxt        = S_STREAM;
                            w_stream_valid_nxt = 1'b1;
                            w_cnt_load         = 1'b1;
                        end
                    end else if (!is_not_vect) begin
                        if (vlen != '0) begin
                            w_state_nxt       = S_VECT;
                            w_vect_active_nxt = 1'b1;
                            w_cnt_load        = 1'b1;
                        end else begin
                            // Empty vector retires immediately, no drain needed.
                            w_pc_nxt             = w_pc_inc;
                            w_done_auto_incr_nxt = 1'b1;
                        end
                    end else if (is_bne && flag_neq) begin
                        w_pc_nxt = branch_immediate;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            S_VECT: begin
                if (w_cnt_tc) begin
                    w_state_nxt          = S_DRAIN;
                    w_done_auto_incr_nxt = 1'b1;
                    w_vect_active_nxt    = 1'b0;
                    w_pc_nxt             = w_pc_inc;
                    w_done_steady_nxt    = 1'b0;
                    w_drain_cnt_nxt      = '0;
                end else begin
                    w_cnt_adv = 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == c_drain_last) begin
                    w_state_nxt       = S_RUN;
                    w_done_steady_nxt = 1'b1;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + c_drain_w'(1);
                end
            end
            S_STREAM: begin
                // The index keeps counting on the final word so it reports words moved.
                if (w_xfer) begin
                    w_cnt_adv = 1'b1;
                    if (w_cnt_tc) begin
                        w_state_nxt        = S_RUN;
                        w_stream_valid_nxt = 1'b0;
                        w_pc_nxt           = w_pc_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_pc             <= '0;
            r_vect_active    <= 1'b0;
            r_done_auto_incr <= 1'b0;
            r_done_steady    <= 1'b1;
            r_stream_valid   <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_drain_cnt      <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_pc             <= w_pc_nxt;
            r_vect_active    <= w_vect_active_nxt;
            r_done_auto_incr <= w_done_auto_incr_nxt;
            r_done_steady    <= w_done_steady_nxt;
            r_stream_valid   <= w_stream_valid_nxt;
            r_busy           <= w_busy_nxt;
            r_done           <= w_done_nxt;
            r_drain_cnt      <= w_drain_cnt_nxt;
        end
    end

    assign pc             = r_pc;
    assign vect_idx       = w_cnt;
    assign vect_active    = r_vect_active;
    assign done_auto_incr = r_done_auto_incr;
    assign done_steady    = r_done_steady;
    assign stream_valid   = r_stream_valid;
    assign busy           = r_busy;
    assign done           = r_done;

`ifdef CGRA_PC_PERF_CNT_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if (w_start_clr) begin
            r_cyc_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if (r_busy) begin
            r_cyc_cnt <= sat_inc32(r_cyc_cnt);
            if (w_pc_nxt == r_pc) begin
                r_stall_cnt <= sat_inc32(r_stall_cnt);
            end
        end
    end

    assign cyc_cnt   = r_cyc_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    logic w_unused_start_clr;
    assign w_unused_start_clr = w_start_clr;
`endif

endmodule
`default_nettype wire

// File: doc/cgra_pc_sequencer.md
Name: cgra_pc_sequencer

Overview:
Sequential program-counter controller for one CGRA tile.
- Owns the PC register.
- Sequences scalar, vector (auto-increment) and vstreamout instructions.
- Generates the element index, done_auto_incr and done_steady handshakes that gate PC advance.
- Sits between the instruction memory (driven by pc) and the decode/datapath stage that supplies instruction-class flags.

Parameters:
- PC_W, 12, PC and branch-immediate width.
- VLEN_W, 10, vector length / element index width.
- DRAIN_CYCLES, 4, pipeline drain cycles after each vector op before the next issue (must be ≥1).

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin execution from PC 0; honoured in IDLE and DONE only.
- instr_valid  in  1  decoded instruction at pc is valid this cycle.
- is_not_vect  in  1  instruction is scalar.
- is_bne  in  1  branch-not-equal.
- flag_neq  in  1  comparison result for bne.
- is_vstreamout  in  1  vector stream-out instruction.
- is_halt  in  1  end of program.
- branch_immediate  in  PC_W  absolute branch target.
- vlen  in  VLEN_W  element count for vector and stream ops.
- stream_ready  in  1  downstream accepts a stream word.
- pc  out  PC_W  current program counter.
- vect_idx  out  VLEN_W  current element index.
- vect_active  out  1  vector op in progress.
- done_auto_incr  out  1  one-cycle pulse on the last element.
- done_steady  out  1  pipeline drained; low during drain.
- stream_valid  out  1  stream word offered.
- busy  out  1  state is not IDLE and not DONE.
- done  out  1  program halted.

Behaviour:
- Reset values: pc=0, vect_idx=0, all 1-bit outputs 0 except done_steady=1; state=IDLE. Reset mid-operation aborts immediately to these values.
- States: IDLE, RUN, VECT, DRAIN, STREAM, DONE. All outputs are registered.
- IDLE/DONE, start=1: pc<=0, done<=0, next state RUN.
- RUN, instr_valid=0: hold pc.
- RUN, instr_valid=1, priority order:
  1. is_halt → DONE, done=1, pc holds.
  2. is_vstreamout → STREAM, stream count loaded.
  3. Vector (is_not_vect=0), vlen≠0 → VECT, vect_idx=0, vect_active=1.
  4. Vector, vlen=0 → pc+1, done_auto_incr pulses this cycle, stay RUN, no drain.
  5. Scalar with is_bne&flag_neq → pc<=branch_immediate.
  6. Any other scalar → pc+1.
- VECT:
  - vect_idx increments each cycle.
  - On vect_idx==vlen-1: done_auto_incr=1 for one cycle, vect_active<=0, pc+1, next state DRAIN.
  - vlen is sampled at entry; later changes are ignored.
- DRAIN: done_steady=0 for exactly DRAIN_CYCLES cycles, pc holds, then done_steady=1 and next state RUN.
- STREAM:
  - stream_valid=1 while words remain; a word transfers when stream_valid&stream_ready.
  - stream_valid never drops without a transfer.
  - vect_idx counts transferred words.
  - After the last transfer: pc+1, stream_valid=0, next state RUN.
  - vlen=0 gives pc+1 with no transfer.
- Latency: scalar issue to pc update is 1 cycle; vector op is vlen+DRAIN_CYCLES cycles.
- PC arithmetic is modulo 2^PC_W: pc=2^PC_W-1 plus 1 wraps to 0. A branch to the current pc is legal (spin).
- start while busy is ignored. Instruction flags are ignored outside RUN.

Optional Feature:
- Macro CGRA_PC_PERF_CNT_EN.
- Defined: adds outputs cyc_cnt[31:0] and stall_cnt[31:0].
  - cyc_cnt counts cycles while busy.
  - stall_cnt counts busy cycles in which pc did not change.
  - Both clear on start and on rst, and saturate at all-ones.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package cgra_seq_pkg holds:
  - the state enum (seq_state_t);
  - default PC_W/VLEN_W constants;
  - the DRAIN_CYCLES default.
- One sub-module, cgra_elem_counter: loadable up-counter with a terminal-count pulse. It is reused by VECT (free-running) and STREAM (advance on handshake).

Test Plan:
- Scalar run: start, 3 scalars then halt at pc=3 → pc 0,1,2,3; done=1 at cycle 5; busy=0.
- Branch: bne at pc=5, flag_neq=1, imm=0x002 → pc=2 next cycle. With flag_neq=0 → pc=6.
- Vector: vlen=4 at pc=7 → vect_idx 0..3, done_auto_incr on idx 3, pc=8 on the same edge, done_steady low for 4 cycles, next issue after that. Repeat with vlen=0 → pc=8 next cycle, no drain.
- Stream: vlen=3 with stream_ready pattern 1,0,0,1,1 → exactly 3 transfers, stream_valid held during stalls, pc+1 after the 3rd transfer.
- Wrap/reset: pc=0xFFF scalar → pc=0x000. Assert rst mid-VECT → all outputs return to reset values asynchronously, state IDLE.
